stream_fifo: RTL and testbench

Parametrised synchronous FIFO with valid/ready stream ports. It replaces the plain rd_en/wr_en FIFO for spike-event and weight streams between the AXI front end, spike router and neuron array. Compile-time options:
- First-word-fall-through (FWFT) or registered-read output mode.
- Backpressure or lossy drop-on-full input policy.

Run-time features: programmable almost-full/empty thresholds, flush, occupancy high-watermark and drop counter.

---
 rtl/stream_fifo.sv | 66 ++++++
 tb/tb_stream_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready synchronous FIFO with optional FWFT output, lossy drop-on-full mode, thresholds and status counters.
module stream_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int FWFT       = 1,
  parameter int DROP_MODE  = 0,
  parameter int DROP_CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       s_valid,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       s_ready,
  output logic                       m_valid,
  output logic [DATA_WIDTH-1:0]      m_data,
  input  logic                       m_ready,
  input  logic [$clog2(DEPTH):0]     af_thresh,
  input  logic [$clog2(DEPTH):0]     ae_thresh,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     max_count,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic                       underflow,
  input  logic                       clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] wr_ptr, rd_ptr, mem_cnt;
  logic full, wr_en, rd_en, drop, uf_ev;
  // In FWFT mode the word parked in the output register still counts as held.
  assign mem_cnt      = wr_ptr - rd_ptr;
  assign count        = mem_cnt + CW'(FWFT != 0 && m_valid);
  assign full         = count == CW'(DEPTH);
  assign s_ready      = rst_n && (DROP_MODE != 0 || !full);
  assign wr_en        = s_valid && s_ready && !flush && !full;
  assign drop         = DROP_MODE != 0 && s_valid && s_ready && !flush && full;
  assign rd_en        = !flush && mem_cnt != '0 && (FWFT != 0 ? (!m_valid || m_ready) : m_ready);
  assign uf_ev        = FWFT == 0 && m_ready && count == '0 && !flush;
  assign almost_full  = count >= af_thresh;
  assign almost_empty = count <= ae_thresh;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= s_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      max_count <= '0;
      drop_cnt  <= '0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + CW'(wr_en);
      rd_ptr    <= flush ? wr_ptr : rd_ptr + CW'(rd_en);
      m_valid   <= !flush && (rd_en || (FWFT != 0 && m_valid && !m_ready));
      if (rd_en) m_data <= mem[rd_ptr[AW-1:0]];
      max_count <= (clr_status || count > max_count) ? count : max_count;
      drop_cnt  <= clr_status ? DROP_CNT_W'(drop) :
                   (drop && drop_cnt != '1) ? drop_cnt + DROP_CNT_W'(1) : drop_cnt;
      underflow <= uf_ev || (underflow && !clr_status);
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed checks of stream_fifo in FWFT, registered-read and drop-on-full builds sharing one stimulus.
module tb_stream_fifo;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0, clr_status = 1'b0;
  logic [7:0] s_data = '0;
  logic [3:0] af_thresh = 4'd6, ae_thresh = 4'd1;
  logic       a_s_ready, a_m_valid, a_af, a_ae, a_uf;
  logic [7:0] a_m_data;
  logic [3:0] a_count, a_max;
  logic [15:0] a_drop;
  logic       b_s_ready, b_m_valid, b_af, b_ae, b_uf;
  logic [7:0] b_m_data;
  logic [3:0] b_count, b_max;
  logic [15:0] b_drop;
  logic       c_s_ready, c_m_valid, c_af, c_ae, c_uf;
  logic [7:0] c_m_data;
  logic [2:0] c_count, c_max;
  logic [3:0] c_drop;
  logic [7:0] q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(1), .DROP_MODE(0), .DROP_CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(a_s_ready),
    .m_valid(a_m_valid), .m_data(a_m_data), .m_ready(m_ready), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count), .max_count(a_max), .drop_cnt(a_drop),
    .underflow(a_uf), .clr_status(clr_status));
  stream_fifo #(.DATA_WIDTH(8), .DEPTH(8), .FWFT(0), .DROP_MODE(0), .DROP_CNT_W(16)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(b_s_ready),
    .m_valid(b_m_valid), .m_data(b_m_data), .m_ready(m_ready), .af_thresh(af_thresh), .ae_thresh(ae_thresh),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count), .max_count(b_max), .drop_cnt(b_drop),
    .underflow(b_uf), .clr_status(clr_status));
  stream_fifo #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1), .DROP_MODE(1), .DROP_CNT_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_data(s_data), .s_ready(c_s_ready),
    .m_valid(c_m_valid), .m_data(c_m_data), .m_ready(m_ready), .af_thresh(af_thresh[2:0]), .ae_thresh(ae_thresh[2:0]),
    .almost_full(c_af), .almost_empty(c_ae), .count(c_count), .max_count(c_max), .drop_cnt(c_drop),
    .underflow(c_uf), .clr_status(clr_status));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; clr_status = 1'b0;
    step; step;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'h77;
    step; step;
    checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", a_count); end
    checks++; if (a_m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", a_m_valid); end
    checks++; if (a_m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data got %0h want 0", a_m_data); end
    checks++; if (a_s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready_low got %0b want 0", a_s_ready); end
    checks++; if (c_s_ready !== 1'b0) begin errors++; $display("FAIL reset_drop_s_ready got %0b want 0", c_s_ready); end
    checks++; if (a_max !== 4'd0 || c_drop !== 4'd0 || b_uf !== 1'b0) begin errors++; $display("FAIL reset_status got max=%0d drop=%0d uf=%0b want 0 0 0", a_max, c_drop, b_uf); end
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    checks++; if (a_s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready_high got %0b want 1", a_s_ready); end
  endtask

  task automatic test_fill;
    do_reset;
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'((i + 1) * 8'h11);
      step;
    end
    checks++; if (a_count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d want 8", a_count); end
    checks++; if (a_s_ready !== 1'b0) begin errors++; $display("FAIL fill_s_ready got %0b want 0", a_s_ready); end
    s_valid = 1'b0;
    step;
    checks++; if (a_max !== 4'd8) begin errors++; $display("FAIL fill_max got %0d want 8", a_max); end
    checks++; if (a_m_valid !== 1'b1 || a_m_data !== 8'h11) begin errors++; $display("FAIL fill_hold got v=%0b d=%0h want 1 11", a_m_valid, a_m_data); end
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_m_valid !== 1'b1 || a_m_data !== 8'((i + 1) * 8'h11)) begin errors++; $display("FAIL drain_%0d got v=%0b d=%0h want 1 %0h", i, a_m_valid, a_m_data, 8'((i + 1) * 8'h11)); end
      step;
    end
    checks++; if (a_count !== 4'd0 || a_m_valid !== 1'b0) begin errors++; $display("FAIL drain_end got count=%0d v=%0b want 0 0", a_count, a_m_valid); end
    m_ready = 1'b0;
  endtask

  task automatic test_almost;
    do_reset;
    checks++; if (a_ae !== 1'b1 || a_af !== 1'b0) begin errors++; $display("FAIL almost_0 got ae=%0b af=%0b want 1 0", a_ae, a_af); end
    s_valid = 1'b1;
    for (int k = 1; k < 8; k++) begin
      s_data = 8'(k);
      step;
      checks++; if (a_count !== 4'(k) || a_ae !== (k <= 1) || a_af !== (k >= 6)) begin errors++; $display("FAIL almost_%0d got count=%0d ae=%0b af=%0b want %0d %0b %0b", k, a_count, a_ae, a_af, k, k <= 1, k >= 6); end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_flush;
    do_reset;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 8'(i + 1);
      step;
    end
    checks++; if (a_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got %0d want 5", a_count); end
    flush = 1'b1; s_data = 8'h99;
    step;
    flush = 1'b0; s_valid = 1'b0;
    checks++; if (a_count !== 4'd0 || a_m_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got count=%0d v=%0b want 0 0", a_count, a_m_valid); end
    checks++; if (a_max !== 4'd5) begin errors++; $display("FAIL flush_max got %0d want 5", a_max); end
    step;
    checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL flush_no_write got %0d want 0", a_count); end
    s_valid = 1'b1; m_ready = 1'b1; s_data = 8'h3C;
    step; step; step;
    rst_n = 1'b0;
    step;
    checks++; if (a_count !== 4'd0 || a_m_valid !== 1'b0 || a_m_data !== 8'h00) begin errors++; $display("FAIL midreset_data got count=%0d v=%0b d=%0h want 0 0 0", a_count, a_m_valid, a_m_data); end
    checks++; if (a_max !== 4'd0 || a_s_ready !== 1'b0) begin errors++; $display("FAIL midreset_status got max=%0d rdy=%0b want 0 0", a_max, a_s_ready); end
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_registered;
    do_reset;
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    checks++; if (b_uf !== 1'b1 || b_m_valid !== 1'b0) begin errors++; $display("FAIL underflow_set got uf=%0b v=%0b want 1 0", b_uf, b_m_valid); end
    checks++; if (a_uf !== 1'b0) begin errors++; $display("FAIL fwft_no_underflow got %0b want 0", a_uf); end
    s_valid = 1'b1; s_data = 8'hA5;
    step;
    s_valid = 1'b0;
    checks++; if (b_count !== 4'd1 || b_m_valid !== 1'b0) begin errors++; $display("FAIL reg_write got count=%0d v=%0b want 1 0", b_count, b_m_valid); end
    m_ready = 1'b1;
    step;
    m_ready = 1'b0;
    checks++; if (b_m_valid !== 1'b1 || b_m_data !== 8'hA5 || b_count !== 4'd0) begin errors++; $display("FAIL reg_read got v=%0b d=%0h count=%0d want 1 a5 0", b_m_valid, b_m_data, b_count); end
    step;
    checks++; if (b_m_valid !== 1'b0 || b_m_data !== 8'hA5) begin errors++; $display("FAIL reg_pulse got v=%0b d=%0h want 0 a5", b_m_valid, b_m_data); end
    clr_status = 1'b1;
    step;
    clr_status = 1'b0;
    checks++; if (b_uf !== 1'b0) begin errors++; $display("FAIL underflow_clr got %0b want 0", b_uf); end
  endtask

  task automatic test_drop;
    do_reset;
    s_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      s_data = 8'(i);
      step;
    end
    checks++; if (c_s_ready !== 1'b1) begin errors++; $display("FAIL drop_s_ready got %0b want 1", c_s_ready); end
    checks++; if (c_count !== 3'd4 || c_drop !== 4'd2) begin errors++; $display("FAIL drop_count got count=%0d drop=%0d want 4 2", c_count, c_drop); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++; if (c_m_valid !== 1'b1 || c_m_data !== 8'(i)) begin errors++; $display("FAIL drop_read_%0d got v=%0b d=%0h want 1 %0h", i, c_m_valid, c_m_data, i); end
      step;
    end
    m_ready = 1'b0;
    checks++; if (c_count !== 3'd0) begin errors++; $display("FAIL drop_empty got %0d want 0", c_count); end
    clr_status = 1'b1;
    step;
    clr_status = 1'b0;
    checks++; if (c_drop !== 4'd0) begin errors++; $display("FAIL drop_clr got %0d want 0", c_drop); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] d;
    do_reset;
    q.delete();
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'hC0 + i);
      q.push_back(s_data);
      step;
    end
    checks++; if (a_count !== 4'd4) begin errors++; $display("FAIL b2b_prefill got %0d want 4", a_count); end
    m_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 255));
      s_data = d;
      checks++; if (a_m_valid !== 1'b1 || a_m_data !== q[0]) begin errors++; $display("FAIL b2b_data_%0d got v=%0b d=%0h want 1 %0h", i, a_m_valid, a_m_data, q[0]); end
      void'(q.pop_front());
      q.push_back(d);
      step;
      checks++; if (a_count !== 4'd4) begin errors++; $display("FAIL b2b_count_%0d got %0d want 4", i, a_count); end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_m_valid !== 1'b1 || a_m_data !== q[0]) begin errors++; $display("FAIL b2b_tail_%0d got v=%0b d=%0h want 1 %0h", i, a_m_valid, a_m_data, q[0]); end
      void'(q.pop_front());
      step;
    end
    m_ready = 1'b0;
    checks++; if (a_count !== 4'd0) begin errors++; $display("FAIL b2b_end got %0d want 0", a_count); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_almost;
    test_flush;
    test_registered;
    test_drop;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
